// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the RV32I control unit
// Opcodes, datapath select encodings, sequencer states, trap causes and
// the decoded control bundle passed from the decoder to the sequencer.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_RESULT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        EXEC     = 2'b00,
        MEM_WAIT = 2'b01,
        TRAP     = 2'b10
    } state_t;

    // reg_write / mem_write are the architectural intent of the instruction;
    // the sequencer gates them with its commit condition.
    typedef struct packed {
        logic [1:0] result_src;
        logic [1:0] pc_src;
        logic       alu_src;
        logic       jump;
        logic       reg_write;
        logic [1:0] imm_src;
        logic [1:0] alu_control;
        logic       mem_write;
    } ctrl_t;

endpackage

// File: rtl/riscv_main_decoder.sv
// rtl/riscv_main_decoder.sv - combinational RV32I main decoder
// Ports: instr (fetched instruction), zero (ALU zero flag) -> ctrl (control
// bundle), is_mem (lw/sw), is_store (sw), illegal (unsupported encoding).
module riscv_main_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        zero,
    output ctrl_t       ctrl,
    output logic        is_mem,
    output logic        is_store,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl     = '0;
        is_mem   = 1'b0;
        is_store = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: ctrl.alu_control = ALU_ADD;
                    10'b0100000_000: ctrl.alu_control = ALU_SUB;
                    10'b0000000_111: ctrl.alu_control = ALU_AND;
                    10'b0000000_110: ctrl.alu_control = ALU_OR;
                    default:         illegal = 1'b1;
                endcase
            end
            OP_I: begin
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_I;
                ctrl.reg_write = 1'b1;
                case (funct3)
                    3'b000:  ctrl.alu_control = ALU_ADD;
                    3'b111:  ctrl.alu_control = ALU_AND;
                    3'b110:  ctrl.alu_control = ALU_OR;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
                is_mem          = 1'b1;
                illegal         = (funct3 != 3'b010);
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
                ctrl.mem_write = 1'b1;
                is_mem         = 1'b1;
                is_store       = 1'b1;
                illegal        = (funct3 != 3'b010);
            end
            OP_BR: begin
                ctrl.imm_src     = IMM_B;
                ctrl.alu_control = ALU_SUB;
                // funct3[0] distinguishes bne from beq and inverts the taken test
                ctrl.pc_src      = (zero ^ funct3[0]) ? PC_TARGET : PC_PLUS4;
                illegal          = (funct3[2:1] != 2'b00);
            end
            OP_JAL: begin
                ctrl.imm_src   = IMM_J;
                ctrl.pc_src    = PC_TARGET;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_JALR: begin
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.result_src = RES_ALU;
                ctrl.pc_src     = PC_RESULT;
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                illegal         = (funct3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl     = '0;
            is_mem   = 1'b0;
            is_store = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_mem_stall_sequencer.sv
// rtl/riscv_mem_stall_sequencer.sv - RV32I control unit with memory stall sequencing
// Ports: CLK, RESET (sync, active-high), Instr, Zero, mem_ack in; datapath
// selects (ResultSrc, PCSrc2, ALUSrc, Jump, ImmSrc, ALUControl), enables
// (RegWrite, MemWrite, mem_req, PCEn), and status (halted, trap_cause,
// retire_count) out.
module riscv_mem_stall_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      Instr,
    input  logic             Zero,
    input  logic             mem_ack,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       PCSrc2,
    output logic             ALUSrc,
    output logic             Jump,
    output logic             RegWrite,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ALUControl,
    output logic             MemWrite,
    output logic             mem_req,
    output logic             PCEn,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retire_count
);

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    ctrl_t             ctrl;
    logic              is_mem;
    logic              is_store;
    logic              illegal;
    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              running;
    logic              commit;
    logic              unused_store;

    riscv_main_decoder u_decoder (
        .instr    (Instr),
        .zero     (Zero),
        .ctrl     (ctrl),
        .is_mem   (is_mem),
        .is_store (is_store),
        .illegal  (illegal)
    );

    // sw vs lw is already carried by ctrl.mem_write / ctrl.reg_write
    assign unused_store = is_store;

    assign ResultSrc  = ctrl.result_src;
    assign PCSrc2     = ctrl.pc_src;
    assign ALUSrc     = ctrl.alu_src;
    assign Jump       = ctrl.jump;
    assign ImmSrc     = ctrl.imm_src;
    assign ALUControl = ctrl.alu_control;

    // Enables are combinational so a zero-wait ack commits in the request cycle.
    assign running  = !RESET && (state != TRAP);
    assign commit   = running && !illegal && (!is_mem || mem_ack);
    assign mem_req  = running && is_mem;
    assign PCEn     = commit;
    assign RegWrite = commit && ctrl.reg_write;
    assign MemWrite = commit && ctrl.mem_write;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= EXEC;
            wait_cnt     <= '0;
            retire_count <= '0;
            trap_cause   <= CAUSE_NONE;
            halted       <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    if (illegal) begin
                        state      <= TRAP;
                        trap_cause <= CAUSE_ILLEGAL;
                        halted     <= 1'b1;
                    end else if (is_mem && !mem_ack) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else begin
                        retire_count <= retire_count + CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    // an ack on the final allowed cycle still wins over the timeout
                    if (mem_ack) begin
                        state        <= EXEC;
                        wait_cnt     <= '0;
                        retire_count <= retire_count + CNT_W'(1);
                    end else if (wait_cnt == WAIT_MAX) begin
                        state      <= TRAP;
                        trap_cause <= CAUSE_TIMEOUT;
                        halted     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_stall_sequencer.sv
// tb/tb_riscv_mem_stall_sequencer.sv - self-checking bench for riscv_mem_stall_sequencer
module tb_riscv_mem_stall_sequencer;

    localparam int TMO = 4;
    localparam int CW  = 4;

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] SUB  = 32'h402081B3;
    localparam logic [31:0] AND_ = 32'h0020F1B3;
    localparam logic [31:0] OR_  = 32'h0020E1B3;
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] ANDI = 32'h00507093;
    localparam logic [31:0] ORI  = 32'h00506093;
    localparam logic [31:0] LW   = 32'h00012083;
    localparam logic [31:0] SW   = 32'h00112223;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] BNE  = 32'h00209463;
    localparam logic [31:0] JALR = 32'h000280E7;
    localparam logic [31:0] JAL  = 32'h008000EF;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   Instr;
    logic          Zero;
    logic          mem_ack;
    logic [1:0]    ResultSrc, PCSrc2, ImmSrc, ALUControl, trap_cause;
    logic          ALUSrc, Jump, RegWrite, MemWrite, mem_req, PCEn, halted;
    logic [CW-1:0] retire_count;

    int total = 0;
    int bad   = 0;

    riscv_mem_stall_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .Instr        (Instr),
        .Zero         (Zero),
        .mem_ack      (mem_ack),
        .ResultSrc    (ResultSrc),
        .PCSrc2       (PCSrc2),
        .ALUSrc       (ALUSrc),
        .Jump         (Jump),
        .RegWrite     (RegWrite),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .MemWrite     (MemWrite),
        .mem_req      (mem_req),
        .PCEn         (PCEn),
        .halted       (halted),
        .trap_cause   (trap_cause),
        .retire_count (retire_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected architectural meaning of an instruction, transcribed from the ISA table.
    typedef struct packed {
        logic       legal;
        logic       mem;
        logic       wr_reg;
        logic       wr_mem;
        logic       jump;
        logic       alus;
        logic [1:0] rs;
        logic [1:0] pcs;
        logic [1:0] imm;
        logic [1:0] aluc;
    } exp_t;

    function automatic exp_t expect_decode(input logic [31:0] i, input logic z);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        e  = '0;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        case (op)
            7'b0110011: begin
                e.wr_reg = 1'b1;
                e.legal  = (f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) ||
                           ((f3 == 3'd7 || f3 == 3'd6) && f7 == 7'h00);
                e.aluc   = (f3 == 3'd7) ? 2'd2 : (f3 == 3'd6) ? 2'd3 : (f7 == 7'h20) ? 2'd1 : 2'd0;
            end
            7'b0010011: begin
                e.wr_reg = 1'b1;
                e.alus   = 1'b1;
                e.legal  = (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6);
                e.aluc   = (f3 == 3'd7) ? 2'd2 : (f3 == 3'd6) ? 2'd3 : 2'd0;
            end
            7'b0000011: begin
                e.legal = (f3 == 3'd2); e.mem = 1'b1; e.wr_reg = 1'b1;
                e.alus  = 1'b1; e.rs = 2'd1;
            end
            7'b0100011: begin
                e.legal = (f3 == 3'd2); e.mem = 1'b1; e.wr_mem = 1'b1;
                e.alus  = 1'b1; e.imm = 2'd1;
            end
            7'b1100011: begin
                e.legal = (f3 <= 3'd1); e.imm = 2'd2; e.aluc = 2'd1;
                e.pcs   = (z != f3[0]) ? 2'd1 : 2'd0;
            end
            7'b1101111: begin
                e.legal = 1'b1; e.imm = 2'd3; e.pcs = 2'd1; e.jump = 1'b1; e.wr_reg = 1'b1;
            end
            7'b1100111: begin
                e.legal = (f3 == 3'd0); e.alus = 1'b1; e.pcs = 2'd2;
                e.jump  = 1'b1; e.wr_reg = 1'b1;
            end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

    exp_t ed;
    always_comb ed = expect_decode(Instr, Zero);

    // Model: has the core trapped, why, how many unanswered request cycles so far, how many retired.
    logic       m_valid   = 1'b0;
    logic       m_trapped = 1'b0;
    logic [1:0] m_cause   = 2'd0;
    int         m_waits   = 0;
    int         m_retired = 0;

    always @(posedge CLK) begin
        if (RESET) begin
            m_valid   <= 1'b1;
            m_trapped <= 1'b0;
            m_cause   <= 2'd0;
            m_waits   <= 0;
            m_retired <= 0;
        end else if (m_valid && !m_trapped) begin
            if (!ed.legal) begin
                m_trapped <= 1'b1;
                m_cause   <= 2'd1;
            end else if (!ed.mem || mem_ack) begin
                m_retired <= m_retired + 1;
                m_waits   <= 0;
            end else if (m_waits == TMO) begin
                m_trapped <= 1'b1;
                m_cause   <= 2'd2;
            end else begin
                m_waits <= m_waits + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("model PCEn",     {31'd0, PCEn},     {31'd0, !RESET && !m_trapped && ed.legal && (!ed.mem || mem_ack)});
            chk("model RegWrite", {31'd0, RegWrite}, {31'd0, !RESET && !m_trapped && ed.legal && ed.wr_reg && (!ed.mem || mem_ack)});
            chk("model MemWrite", {31'd0, MemWrite}, {31'd0, !RESET && !m_trapped && ed.legal && ed.wr_mem && mem_ack});
            chk("model mem_req",  {31'd0, mem_req},  {31'd0, !RESET && !m_trapped && ed.legal && ed.mem});
            chk("model halted",   {31'd0, halted},   {31'd0, m_trapped});
            chk("model trap_cause", {30'd0, trap_cause}, {30'd0, m_cause});
            chk("model retire_count", {28'd0, retire_count}, 32'(m_retired % (1 << CW)));
            if (!RESET && !m_trapped && ed.legal) begin
                chk("model ResultSrc",  {30'd0, ResultSrc},  {30'd0, ed.rs});
                chk("model PCSrc2",     {30'd0, PCSrc2},     {30'd0, ed.pcs});
                chk("model ALUSrc",     {31'd0, ALUSrc},     {31'd0, ed.alus});
                chk("model Jump",       {31'd0, Jump},       {31'd0, ed.jump});
                chk("model ImmSrc",     {30'd0, ImmSrc},     {30'd0, ed.imm});
                chk("model ALUControl", {30'd0, ALUControl}, {30'd0, ed.aluc});
            end
        end
    end

    task automatic step(input logic r, input logic [31:0] i, input logic z, input logic a);
        @(posedge CLK);
        #1;
        RESET = r; Instr = i; Zero = z; mem_ack = a;
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1; Instr = ADD; Zero = 1'b0; mem_ack = 1'b0;
        step(1, ADD, 0, 0);
        chk("reset retire", {28'd0, retire_count}, 32'd0);
        chk("reset halted", {31'd0, halted}, 32'd0);
        chk("reset cause", {30'd0, trap_cause}, 32'd0);
        chk("reset PCEn", {31'd0, PCEn}, 32'd0);
        chk("reset RegWrite", {31'd0, RegWrite}, 32'd0);

        step(0, ADD, 0, 0);
        chk("add RegWrite", {31'd0, RegWrite}, 32'd1);
        chk("add PCEn", {31'd0, PCEn}, 32'd1);
        chk("add ALUSrc", {31'd0, ALUSrc}, 32'd0);
        chk("add ALUControl", {30'd0, ALUControl}, 32'd0);
        chk("add retire before", {28'd0, retire_count}, 32'd0);

        step(0, LW, 0, 0);
        chk("lw retire", {28'd0, retire_count}, 32'd1);
        chk("lw req c1", {31'd0, mem_req}, 32'd1);
        chk("lw PCEn c1", {31'd0, PCEn}, 32'd0);
        step(0, LW, 0, 0);
        step(0, LW, 0, 0);
        chk("lw RegWrite c3", {31'd0, RegWrite}, 32'd0);
        chk("lw req c3", {31'd0, mem_req}, 32'd1);
        step(0, LW, 0, 1);
        chk("lw ack RegWrite", {31'd0, RegWrite}, 32'd1);
        chk("lw ack ResultSrc", {30'd0, ResultSrc}, 32'd1);
        chk("lw ack PCEn", {31'd0, PCEn}, 32'd1);
        step(0, LW, 0, 1);
        chk("lw0 PCEn", {31'd0, PCEn}, 32'd1);
        chk("lw0 retire", {28'd0, retire_count}, 32'd2);
        step(0, ADD, 0, 1);
        chk("stray ack retire", {28'd0, retire_count}, 32'd3);

        step(0, BEQ, 1, 0);
        chk("beq z1", {30'd0, PCSrc2}, 32'd1);
        chk("beq RegWrite", {31'd0, RegWrite}, 32'd0);
        step(0, BEQ, 0, 0);
        chk("beq z0", {30'd0, PCSrc2}, 32'd0);
        step(0, BNE, 1, 0);
        chk("bne z1", {30'd0, PCSrc2}, 32'd0);
        step(0, BNE, 0, 0);
        chk("bne z0", {30'd0, PCSrc2}, 32'd1);
        chk("bne RegWrite", {31'd0, RegWrite}, 32'd0);

        step(0, JALR, 0, 0);
        chk("jalr Jump", {31'd0, Jump}, 32'd1);
        chk("jalr PCSrc2", {30'd0, PCSrc2}, 32'd2);
        chk("jalr ALUSrc", {31'd0, ALUSrc}, 32'd1);
        chk("jalr ImmSrc", {30'd0, ImmSrc}, 32'd0);
        chk("jalr RegWrite", {31'd0, RegWrite}, 32'd1);
        step(0, JAL, 0, 0);
        chk("jal ImmSrc", {30'd0, ImmSrc}, 32'd3);
        chk("jal PCSrc2", {30'd0, PCSrc2}, 32'd1);

        step(0, SUB, 0, 0);
        chk("sub ALUControl", {30'd0, ALUControl}, 32'd1);
        step(0, AND_, 0, 0);
        step(0, OR_, 0, 0);
        step(0, ADDI, 0, 0);
        step(0, ANDI, 0, 0);
        chk("andi ALUControl", {30'd0, ALUControl}, 32'd2);
        step(0, ORI, 0, 0);
        chk("ori retire", {28'd0, retire_count}, 32'd15);
        step(0, ADD, 0, 0);
        chk("retire wrap", {28'd0, retire_count}, 32'd0);

        step(0, 32'h0, 0, 0);
        chk("illegal PCEn", {31'd0, PCEn}, 32'd0);
        step(0, ADD, 0, 0);
        chk("illegal halted", {31'd0, halted}, 32'd1);
        chk("illegal cause", {30'd0, trap_cause}, 32'd1);
        for (int k = 0; k < 20; k++) step(0, ADD, 0, 1'($urandom_range(0, 1)));
        chk("trap PCEn", {31'd0, PCEn}, 32'd0);
        chk("trap retire frozen", {28'd0, retire_count}, 32'd1);
        step(1, ADD, 0, 0);
        step(0, ADD, 0, 0);
        chk("post trap halted", {31'd0, halted}, 32'd0);
        chk("post trap cause", {30'd0, trap_cause}, 32'd0);
        chk("post trap retire", {28'd0, retire_count}, 32'd0);

        for (int k = 0; k < 4; k++) step(0, SW, 0, 0);
        step(0, SW, 0, 1);
        chk("sw last-cycle ack MemWrite", {31'd0, MemWrite}, 32'd1);
        chk("sw last-cycle ack PCEn", {31'd0, PCEn}, 32'd1);

        for (int k = 0; k < 5; k++) step(0, SW, 0, 0);
        step(0, ADD, 0, 0);
        chk("timeout halted", {31'd0, halted}, 32'd1);
        chk("timeout cause", {30'd0, trap_cause}, 32'd2);
        chk("timeout retire", {28'd0, retire_count}, 32'd2);

        step(1, ADD, 0, 0);
        step(0, LW, 0, 0);
        step(0, LW, 0, 0);
        chk("wait req", {31'd0, mem_req}, 32'd1);
        step(1, LW, 0, 0);
        chk("reset in wait req", {31'd0, mem_req}, 32'd0);
        step(0, ADD, 0, 0);
        chk("after reset req", {31'd0, mem_req}, 32'd0);
        chk("after reset PCEn", {31'd0, PCEn}, 32'd1);
        step(0, ADD, 0, 0);
        chk("after reset retire", {28'd0, retire_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_mem_stall_sequencer.md
Name: riscv_mem_stall_sequencer

Overview:
- Control unit for the single-cycle RV32I datapath.
- Decodes the fetched instruction and drives every datapath control input.
- Sequences data-memory accesses over a req/ack handshake, stalling the PC while memory is not ready.
- Traps and halts on illegal instructions or memory timeouts; counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, max wait cycles in MEM_WAIT before trapping (>=1)
CNT_W, 32, width of retire counter

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
Instr  in  32  current instruction (stable while PC held)
Zero  in  1  ALU zero flag
mem_ack  in  1  data memory ready/complete this cycle
ResultSrc  out  2  00 ALUResult, 01 ReadData, 10 PCPlus4
PCSrc2  out  2  00 PCPlus4, 01 PCTarget, 10 Result (jalr)
ALUSrc  out  1  0 register, 1 ImmExt
Jump  out  1  1 selects PCPlus4 as register write data
RegWrite  out  1  register file write enable
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
ALUControl  out  2  00 add, 01 sub, 10 and, 11 or
MemWrite  out  1  data memory write strobe
mem_req  out  1  data memory access request
PCEn  out  1  PC register update enable
halted  out  1  sequencer in TRAP
trap_cause  out  2  00 none, 01 illegal, 10 mem timeout
retire_count  out  CNT_W  retired instruction count

Behaviour:
- Reset: state=EXEC, wait_cnt=0, retire_count=0, trap_cause=00, halted=0. While RESET=1, RegWrite, MemWrite, mem_req and PCEn are forced 0; other outputs are don't-care.
- Decode (combinational from Instr):
  - R-type 0110011: funct3/funct7 add/sub/and/or map to ALUControl 00/01/10/11; ALUSrc=0, RegWrite=1.
  - I-ALU 0010011: addi/andi/ori; ALUSrc=1, ImmSrc=00, RegWrite=1.
  - lw 0000011: ALUSrc=1, ImmSrc=00, ALUControl=00, ResultSrc=01.
  - sw 0100011: ALUSrc=1, ImmSrc=01, ALUControl=00.
  - beq/bne 1100011 (funct3 000/001): ALUSrc=0, ImmSrc=10, ALUControl=01; PCSrc2=01 if (Zero XOR bne) else 00.
  - jal 1101111: ImmSrc=11, PCSrc2=01, Jump=1, RegWrite=1.
  - jalr 1100111 (funct3 000): ALUSrc=1, ImmSrc=00, ALUControl=00, ResultSrc=00, PCSrc2=10, Jump=1, RegWrite=1.
  - Any other opcode/funct combination is illegal.
  - Unused selects default to 0.
- State EXEC:
  - Legal non-memory instruction: PCEn=1, retire_count+1, stay in EXEC.
  - lw/sw: mem_req=1.
    - If mem_ack=1 in the same cycle (zero wait): commit now — RegWrite=1 (lw) or MemWrite=1 (sw), PCEn=1, retire+1.
    - Otherwise: RegWrite=MemWrite=PCEn=0, wait_cnt=1, go to MEM_WAIT.
  - Illegal: all enables 0; next state TRAP, trap_cause<=01.
- State MEM_WAIT:
  - mem_req=1; decoded controls held (Instr stable).
  - mem_ack=1: commit as above, go to EXEC, wait_cnt<=0.
  - Else if wait_cnt==MEM_TIMEOUT: go to TRAP, trap_cause<=10; no write strobe is ever issued.
  - Else wait_cnt+1.
  - mem_ack is sampled only while mem_req=1. A stray ack in EXEC for a non-memory instruction is ignored.
- State TRAP: halted=1; PCEn, RegWrite, MemWrite, mem_req all 0; retire_count frozen. Exits only on RESET.
- retire_count wraps modulo 2^CNT_W.
- RESET mid-MEM_WAIT: next cycle is EXEC with mem_req=0; the access is abandoned.
- RESET has priority over every transition.

Decomposition:
- Package riscv_ctrl_pkg holds: opcode constants; ALUControl, ImmSrc, ResultSrc and PCSrc2 encodings; state enum {EXEC, MEM_WAIT, TRAP}; trap_cause codes.
- Sub-module riscv_main_decoder (pure combinational: Instr, Zero -> control bundle, is_mem, is_store, illegal).
- FSM, wait counter and retire counter live in the top.

Test Plan:
- RESET then add x3,x1,x2 (0x002081B3) -> RegWrite=1, ALUSrc=0, ALUControl=00, ResultSrc=00, PCEn=1; retire_count 0->1.
- lw x1,0(x2) (0x00012083) with mem_ack after 3 cycles -> mem_req high 4 cycles; PCEn=RegWrite=0 for 3 cycles; ack cycle gives RegWrite=1, ResultSrc=01, PCEn=1; retire+1. Repeat with ack in the first cycle -> 1-cycle completion.
- beq (0x00208463): Zero=1 -> PCSrc2=01, Zero=0 -> 00. Same with bne (funct3 001) -> inverted. RegWrite=0 in all cases.
- jalr x1,0(x5) (0x000280E7) -> Jump=1, PCSrc2=10, ALUSrc=1, ImmSrc=00, RegWrite=1. jal -> ImmSrc=11, PCSrc2=01.
- Instr=0x00000000 -> next cycle halted=1, trap_cause=01; PCEn=0 and retire frozen for 20 cycles; RESET clears to EXEC, trap_cause=00.
- sw (0x00112223) with MEM_TIMEOUT=4 and mem_ack never asserted -> TRAP with trap_cause=10, MemWrite never 1. Separate run: RESET asserted in MEM_WAIT -> next cycle EXEC, mem_req=0.
